// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache-port arbiter: state encodings and parameter defaults.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_BUSY_I = 2'b01,
      ARB_BUSY_D = 2'b10
   } arb_state_t;

   localparam int MAX_WAIT_DEF = 4;
   localparam int WAIT_W_DEF   = 3;

endpackage

// File: rtl/arb_req_latch.sv
// Holds the granted request so the cache controller sees stable inputs for the
// whole transaction.
module arb_req_latch (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] addr_nxt,
   input  logic [15:0] data_nxt,
   input  logic        rd_nxt,
   input  logic        wr_nxt,
   output logic [15:0] addr,
   output logic [15:0] data,
   output logic        rd,
   output logic        wr
);

   // capture the winning request on a grant, clear on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= 16'h0;
         data <= 16'h0;
         rd   <= 1'b0;
         wr   <= 1'b0;
      end else if (load) begin
         addr <= addr_nxt;
         data <= data_nxt;
         rd   <= rd_nxt;
         wr   <= wr_nxt;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cache controller between the fetch port and the data port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no owner; cache inputs held at 0; arbitrate every cycle
// ARB_BUSY_I | fetch owns the cache; arbitrate again on c_done
// ARB_BUSY_D | data owns the cache; arbitrate again on c_done
//
// Data has fixed priority unless a pending fetch has waited MAX_WAIT or more
// cycles. The port completing on a given c_done is excluded from that
// arbitration because its request is still high for that one cycle.
import mem_arbiter_pkg::*;

module mem_arbiter #(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int WAIT_W   = WAIT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rd,
   input  logic [15:0] i_addr,
   input  logic        i_flush,
   output logic [15:0] i_data_out,
   output logic        i_done,
   output logic        i_hit,
   output logic        i_stall,
   output logic        i_err,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_data_in,
   output logic [15:0] d_data_out,
   output logic        d_done,
   output logic        d_hit,
   output logic        d_stall,
   output logic        d_err,
   output logic [15:0] c_addr,
   output logic [15:0] c_data_in,
   output logic        c_read,
   output logic        c_write,
   input  logic [15:0] c_data_out,
   input  logic        c_done,
   input  logic        c_hit,
   input  logic        c_err
);

   arb_state_t        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              flushed;

   logic              ip, dp, d_ill;
   logic              arb_pt, cand_i, cand_d, grant_i, grant_d;
   logic              busy_i, busy_d, busy, flush_now;
   logic [15:0]       nxt_addr, nxt_data;
   logic              nxt_rd, nxt_wr;
   logic [15:0]       l_addr, l_data;
   logic              l_rd, l_wr;

   // pending requests and the grant decision for this edge
   always_comb begin
      ip      = i_rd & ~i_flush;
      dp      = d_rd ^ d_wr;
      d_ill   = d_rd & d_wr;
      arb_pt  = (state == ARB_IDLE) | c_done;
      cand_i  = ip & (state != ARB_BUSY_I);
      cand_d  = dp & (state != ARB_BUSY_D);
      grant_i = arb_pt & cand_i & (~cand_d | (wait_cnt >= WAIT_W'(MAX_WAIT)));
      grant_d = arb_pt & cand_d & ~grant_i;
      // fetches never carry write data, so the data field is parked at 0
      nxt_addr = grant_i ? i_addr : d_addr;
      nxt_data = grant_i ? 16'h0  : d_data_in;
      nxt_rd   = grant_i ? 1'b1   : d_rd;
      nxt_wr   = grant_i ? 1'b0   : d_wr;
   end

   arb_req_latch u_latch (
      .clk      (clk),
      .rst_n    (rst),
      .load     (grant_i | grant_d),
      .addr_nxt (nxt_addr),
      .data_nxt (nxt_data),
      .rd_nxt   (nxt_rd),
      .wr_nxt   (nxt_wr),
      .addr     (l_addr),
      .data     (l_data),
      .rd       (l_rd),
      .wr       (l_wr)
   );

   // ownership state, fetch starvation counter and flush marker
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ARB_IDLE;
         wait_cnt <= '0;
         flushed  <= 1'b0;
      end else begin
         if (arb_pt) begin
            if (grant_i)      state <= ARB_BUSY_I;
            else if (grant_d) state <= ARB_BUSY_D;
            else              state <= ARB_IDLE;
         end
         if (!ip || grant_i)
            wait_cnt <= '0;
         else if (state != ARB_BUSY_I && wait_cnt != {WAIT_W{1'b1}})
            wait_cnt <= wait_cnt + 1'b1;
         // a fill cannot be aborted, so a flush only hides the eventual completion
         if (state == ARB_BUSY_I && c_done)
            flushed <= 1'b0;
         else if (state == ARB_BUSY_I && i_flush)
            flushed <= 1'b1;
      end
   end

   // route completion back to the owner; everything is held at 0 during reset
   always_comb begin
      busy_i    = rst & (state == ARB_BUSY_I);
      busy_d    = rst & (state == ARB_BUSY_D);
      busy      = busy_i | busy_d;
      flush_now = flushed | i_flush;

      i_done     = busy_i & c_done & ~flush_now;
      i_data_out = i_done ? c_data_out : 16'h0;
      i_hit      = i_done & c_hit;
      i_err      = busy_i & c_err & ~flush_now;
      i_stall    = rst & ip & ~i_done;

      d_done     = busy_d & c_done;
      d_data_out = d_done ? c_data_out : 16'h0;
      d_hit      = d_done & c_hit;
      d_err      = rst & ((busy_d & c_err) | d_ill);
      d_stall    = rst & dp & ~d_done;

      c_addr     = busy ? l_addr : 16'h0;
      c_data_in  = busy ? l_data : 16'h0;
      c_read     = busy & l_rd;
      c_write    = busy & l_wr;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level ownership model.
module tb_mem_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rd, i_flush;
   logic [15:0] i_addr;
   logic [15:0] i_data_out;
   logic        i_done, i_hit, i_stall, i_err;
   logic        d_rd, d_wr;
   logic [15:0] d_addr, d_data_in;
   logic [15:0] d_data_out;
   logic        d_done, d_hit, d_stall, d_err;
   logic [15:0] c_addr, c_data_in;
   logic        c_read, c_write;
   logic [15:0] c_data_out;
   logic        c_done, c_hit, c_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
      .clk(clk), .rst(rst),
      .i_rd(i_rd), .i_addr(i_addr), .i_flush(i_flush),
      .i_data_out(i_data_out), .i_done(i_done), .i_hit(i_hit),
      .i_stall(i_stall), .i_err(i_err),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
      .d_data_out(d_data_out), .d_done(d_done), .d_hit(d_hit),
      .d_stall(d_stall), .d_err(d_err),
      .c_addr(c_addr), .c_data_in(c_data_in), .c_read(c_read), .c_write(c_write),
      .c_data_out(c_data_out), .c_done(c_done), .c_hit(c_hit), .c_err(c_err)
   );

   function automatic logic [73:0] outs();
      return {i_data_out, i_done, i_hit, i_stall, i_err,
              d_data_out, d_done, d_hit, d_stall, d_err,
              c_addr, c_data_in, c_read, c_write};
   endfunction

   task automatic clear_inputs();
      i_rd = 0; i_addr = 0; i_flush = 0;
      d_rd = 0; d_wr = 0; d_addr = 0; d_data_in = 0;
      c_data_out = 0; c_done = 0; c_hit = 0; c_err = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 0; clear_inputs();
      i_rd = 1; d_rd = 1; d_wr = 1; c_err = 1; c_done = 1;
      #1;
      total++;
      if (outs() !== 74'h0) begin
         bad++; $display("FAIL reset_outputs actual=%h required=0", outs());
      end
      @(negedge clk);
      clear_inputs(); rst = 1;
      #1;
      total++;
      if (dut.state !== 2'b00 || dut.wait_cnt !== 3'd0) begin
         bad++; $display("FAIL reset_state actual state=%0d wait=%0d required 0/0", dut.state, dut.wait_cnt);
      end
   endtask

   task automatic test_fetch_hit();
      @(negedge clk);
      i_rd = 1; i_addr = 16'h0040;
      #1;
      total++;
      if (i_stall !== 1'b1 || c_read !== 1'b0) begin
         bad++; $display("FAIL hit_cycle_n actual stall=%b c_read=%b required 1/0", i_stall, c_read);
      end
      @(negedge clk);
      c_done = 1; c_hit = 1; c_data_out = 16'hBEEF;
      #1;
      total++;
      if ({c_read, c_addr, i_done, i_data_out, i_hit, i_stall} !== {1'b1, 16'h0040, 1'b1, 16'hBEEF, 1'b1, 1'b0}) begin
         bad++; $display("FAIL hit_cycle_n1 actual rd=%b addr=%h done=%b data=%h hit=%b stall=%b required 1/0040/1/beef/1/0",
                         c_read, c_addr, i_done, i_data_out, i_hit, i_stall);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      total++;
      if (c_read !== 1'b0 || i_done !== 1'b0) begin
         bad++; $display("FAIL hit_return_idle actual c_read=%b i_done=%b required 0/0", c_read, i_done);
      end
   endtask

   task automatic test_contention();
      @(negedge clk);
      i_rd = 1; i_addr = 16'h0200;
      d_wr = 1; d_addr = 16'h0100; d_data_in = 16'h1234;
      @(negedge clk);
      c_done = 1; c_hit = 1; c_data_out = 16'h0;
      #1;
      total++;
      if ({c_write, c_read, c_addr, c_data_in, d_done, i_stall} !== {1'b1, 1'b0, 16'h0100, 16'h1234, 1'b1, 1'b1}) begin
         bad++; $display("FAIL contention_data_first actual wr=%b rd=%b addr=%h wdata=%h d_done=%b i_stall=%b",
                         c_write, c_read, c_addr, c_data_in, d_done, i_stall);
      end
      @(negedge clk);
      d_wr = 0; c_done = 0;
      #1;
      total++;
      if ({c_read, c_write, c_addr} !== {1'b1, 1'b0, 16'h0200}) begin
         bad++; $display("FAIL contention_handoff actual rd=%b wr=%b addr=%h required 1/0/0200", c_read, c_write, c_addr);
      end
      @(negedge clk);
      c_done = 1; c_hit = 0; c_data_out = 16'h5555;
      #1;
      total++;
      if ({i_done, i_data_out, i_hit} !== {1'b1, 16'h5555, 1'b0}) begin
         bad++; $display("FAIL contention_fetch_done actual done=%b data=%h hit=%b required 1/5555/0", i_done, i_data_out, i_hit);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_starvation();
      int exp_w;
      @(negedge clk);
      i_rd = 1; i_addr = 16'h0500;
      d_rd = 1; d_addr = 16'h0600;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         exp_w = (k + 1 > 7) ? 7 : k + 1;
         total++;
         if (c_addr !== 16'h0600 || c_read !== 1'b1 || dut.wait_cnt !== 3'(exp_w)) begin
            bad++; $display("FAIL starve_wait_%0d actual addr=%h wait=%0d required 0600/%0d", k, c_addr, dut.wait_cnt, exp_w);
         end
      end
      @(negedge clk);
      c_done = 1; c_hit = 1; c_data_out = 16'hAAAA;
      d_addr = 16'h0604;
      #1;
      total++;
      if (d_done !== 1'b1 || d_data_out !== 16'hAAAA) begin
         bad++; $display("FAIL starve_d_done actual done=%b data=%h required 1/aaaa", d_done, d_data_out);
      end
      @(negedge clk);
      c_done = 0;
      #1;
      total++;
      if (c_addr !== 16'h0500 || c_read !== 1'b1 || dut.wait_cnt !== 3'd0 || d_stall !== 1'b1) begin
         bad++; $display("FAIL starve_fetch_grant actual addr=%h wait=%0d d_stall=%b required 0500/0/1", c_addr, dut.wait_cnt, d_stall);
      end
      @(negedge clk);
      c_done = 1; c_data_out = 16'h7777;
      #1;
      total++;
      if (i_done !== 1'b1 || i_data_out !== 16'h7777) begin
         bad++; $display("FAIL starve_i_done actual done=%b data=%h required 1/7777", i_done, i_data_out);
      end
      @(negedge clk);
      i_rd = 0; c_done = 0;
      #1;
      total++;
      if (c_addr !== 16'h0604 || c_read !== 1'b1) begin
         bad++; $display("FAIL back_to_back_d actual addr=%h rd=%b required 0604/1", c_addr, c_read);
      end
      @(negedge clk);
      c_done = 1;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_flush_miss();
      int seen_done;
      seen_done = 0;
      @(negedge clk);
      i_rd = 1; i_addr = 16'h0300;
      @(negedge clk);
      @(negedge clk);
      i_flush = 1; i_rd = 0;
      #1;
      if (i_done) seen_done++;
      @(negedge clk);
      i_flush = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (c_read !== 1'b1 || c_addr !== 16'h0300) begin
            bad++; $display("FAIL flush_hold_%0d actual rd=%b addr=%h required 1/0300", k, c_read, c_addr);
         end
         if (i_done) seen_done++;
         @(negedge clk);
      end
      c_done = 1; c_hit = 1; c_data_out = 16'hDEAD;
      i_rd = 1; i_addr = 16'h0304;
      #1;
      if (i_done) seen_done++;
      total++;
      if (seen_done != 0 || i_hit !== 1'b0 || i_data_out !== 16'h0) begin
         bad++; $display("FAIL flush_suppress actual dones=%0d hit=%b data=%h required 0/0/0000", seen_done, i_hit, i_data_out);
      end
      @(negedge clk);
      c_done = 0;
      #1;
      total++;
      if (c_read !== 1'b0) begin
         bad++; $display("FAIL flush_idle_gap actual rd=%b required 0", c_read);
      end
      @(negedge clk);
      #1;
      total++;
      if (c_read !== 1'b1 || c_addr !== 16'h0304) begin
         bad++; $display("FAIL flush_next_fetch actual rd=%b addr=%h required 1/0304", c_read, c_addr);
      end
      @(negedge clk);
      c_done = 1;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_illegal();
      @(negedge clk);
      d_rd = 1; d_wr = 1; d_addr = 16'h0900;
      #1;
      total++;
      if ({d_err, c_read, c_write, d_stall} !== 4'b1000) begin
         bad++; $display("FAIL illegal_op actual err=%b rd=%b wr=%b stall=%b required 1/0/0/0", d_err, c_read, c_write, d_stall);
      end
      @(negedge clk);
      #1;
      total++;
      if (dut.state !== 2'b00 || c_read !== 1'b0 || c_write !== 1'b0) begin
         bad++; $display("FAIL illegal_stay_idle actual state=%0d rd=%b wr=%b required 0/0/0", dut.state, c_read, c_write);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid_miss();
      @(negedge clk);
      d_rd = 1; d_addr = 16'h0700; i_rd = 1; i_addr = 16'h0708;
      @(negedge clk);
      #1;
      total++;
      if (c_read !== 1'b1 || c_addr !== 16'h0700) begin
         bad++; $display("FAIL rstmiss_busy actual rd=%b addr=%h required 1/0700", c_read, c_addr);
      end
      @(negedge clk);
      #2 rst = 0;
      #1;
      total++;
      if (outs() !== 74'h0 || dut.state !== 2'b00 || dut.wait_cnt !== 3'd0) begin
         bad++; $display("FAIL rstmiss_clear actual outs=%h state=%0d wait=%0d required 0/0/0", outs(), dut.state, dut.wait_cnt);
      end
      clear_inputs();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_random();
      int owner, lat, m_wait, g, r;
      bit m_fl, ap, ci, cd, ei_done, ed_done, e_ierr, e_derr, ipn, dpn, ill, fl;
      bit f_act, f_drop, d_act, d_drop, drd, dwr;
      logic [15:0] la, ld, fa, da, dd;
      logic lr, lw;
      logic [73:0] exp_v;
      do_reset();
      owner = 0; lat = 0; m_wait = 0; m_fl = 0;
      la = 0; ld = 0; lr = 0; lw = 0;
      f_act = 0; f_drop = 0; d_act = 0; d_drop = 0; drd = 0; dwr = 0;
      fa = 0; da = 0; dd = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (f_drop) f_act = 0;
         if (d_drop) d_act = 0;
         if (!f_act && $urandom_range(2) == 0) begin f_act = 1; fa = 16'($urandom); end
         ill = 0;
         if (!d_act) begin
            r = $urandom_range(19);
            if (r < 6) begin
               d_act = 1; drd = (r < 3); dwr = (r >= 3);
               da = 16'($urandom); dd = 16'($urandom);
            end else if (r == 19) ill = 1;
         end
         i_rd = f_act; i_addr = fa;
         i_flush = f_act && ($urandom_range(15) == 0);
         d_rd = d_act ? drd : ill;
         d_wr = d_act ? dwr : ill;
         d_addr = d_act ? da : 16'($urandom);
         d_data_in = d_act ? dd : 16'($urandom);
         c_done = (owner != 0) && (lat == 0);
         c_data_out = 16'($urandom); c_hit = 1'($urandom); c_err = ($urandom_range(9) == 0);
         #1;
         ipn = i_rd && !i_flush;
         dpn = d_rd ^ d_wr;
         fl = (owner == 1) && (m_fl || i_flush);
         ei_done = (owner == 1) && c_done && !fl;
         ed_done = (owner == 2) && c_done;
         e_ierr = (owner == 1) && c_err && !fl;
         e_derr = ((owner == 2) && c_err) || (d_rd && d_wr);
         exp_v = {ei_done ? c_data_out : 16'h0, ei_done, ei_done && c_hit, ipn && !ei_done, e_ierr,
                  ed_done ? c_data_out : 16'h0, ed_done, ed_done && c_hit, dpn && !ed_done, e_derr,
                  (owner != 0) ? la : 16'h0, (owner != 0) ? ld : 16'h0,
                  (owner != 0) && lr, (owner != 0) && lw};
         total++;
         if (outs() !== exp_v) begin
            bad++; $display("FAIL random_cycle_%0d actual=%h required=%h owner=%0d", cyc, outs(), exp_v, owner);
         end
         // advance the model across the coming edge
         ap = (owner == 0) || c_done;
         ci = ipn && owner != 1;
         cd = dpn && owner != 2;
         g = 0;
         if (ap) begin
            if (ci && cd)  g = (m_wait >= MAX_WAIT) ? 1 : 2;
            else if (ci)   g = 1;
            else if (cd)   g = 2;
         end
         if (!ipn || g == 1)  m_wait = 0;
         else if (owner != 1) m_wait = (m_wait == 7) ? 7 : m_wait + 1;
         if (owner == 1 && c_done)       m_fl = 0;
         else if (owner == 1 && i_flush) m_fl = 1;
         if (g == 1) begin la = i_addr; ld = 16'h0; lr = 1; lw = 0; end
         if (g == 2) begin la = d_addr; ld = d_data_in; lr = d_rd; lw = d_wr; end
         if (ap) owner = g;
         if (ap && g != 0) lat = $urandom_range(3);
         else if (owner != 0 && lat > 0) lat--;
         f_drop = ei_done || i_flush;
         d_drop = ed_done;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      rst = 0;
      clear_inputs();
      test_reset();
      test_fetch_hit();
      test_contention();
      test_starvation();
      test_flush_miss();
      test_illegal();
      test_reset_mid_miss();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single cache controller (cache FSM plus four-bank memory) between the instruction-fetch port and the data-memory port of the pipeline. Arbitrates between the ports and latches the granted request so the cache sees stable inputs for the whole transaction. Routes done, data, hit and error back to the owning port and generates per-port stalls. Data has fixed priority, with an anti-starvation override for fetch and a fetch-flush path.

Parameters:
MAX_WAIT, 4, cycles a pending fetch may lose to data before it is forced to win
WAIT_W, 3, width of the fetch wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
i_rd  in  1  fetch read request, held until i_done
i_addr  in  16  fetch address
i_flush  in  1  discard the current or pending fetch
i_data_out  out  16  fetched word, valid when i_done
i_done  out  1  fetch complete pulse
i_hit  out  1  fetch was a cache hit, valid with i_done
i_stall  out  1  fetch stall
i_err  out  1  fetch error
d_rd  in  1  data read request, held until d_done
d_wr  in  1  data write request, held until d_done
d_addr  in  16  data address
d_data_in  in  16  store data
d_data_out  out  16  load data, valid when d_done
d_done  out  1  data complete pulse
d_hit  out  1  data hit, valid with d_done
d_stall  out  1  data stall
d_err  out  1  data error
c_addr  out  16  cache controller address
c_data_in  out  16  cache controller write data
c_read  out  1  cache controller read
c_write  out  1  cache controller write
c_data_out  in  16  cache controller read data
c_done  in  1  cache controller done
c_hit  in  1  cache controller hit
c_err  in  1  cache controller error

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Reset (rst=0, asynchronous) forces IDLE, clears the latch registers and wait_cnt, and clears flushed. Every output is 0 while in reset.
- Pending signals:
  - ip = i_rd & ~i_flush.
  - dp = (d_rd ^ d_wr).
  - If d_rd & d_wr: d_err=1 combinationally, that request is never granted, and d_stall=0.
- Grant decision, sampled at each clock edge in IDLE, or in BUSY_x when c_done=1:
  - The port completing this cycle is excluded, because its request is still high for this one cycle.
  - If both ports are pending: data wins, unless wait_cnt >= MAX_WAIT, in which case fetch wins.
  - Otherwise the single pending port wins. If nothing is pending, go to IDLE.
  - When c_done=1 and the other port is pending, hand off directly with no bubble.
- On a grant: the latch captures addr, data and op. In BUSY_x, c_addr, c_data_in, c_read and c_write are driven only from the latch. In IDLE, all c_* outputs are 0.
- Fetch grants always use c_read=1 and c_write=0.
- Completion in BUSY_x when c_done=1:
  - Assert x_done, x_data_out=c_data_out and x_hit=c_hit for that cycle, all combinational.
  - Otherwise x_data_out=0 and x_hit=0.
- Latency: request at cycle N, grant at the edge ending N, cache hit gives done at N+1. A miss takes the cache FSM's latency plus 1.
- Stalls: i_stall = i_rd & ~i_flush & ~i_done; d_stall = dp & ~d_done.
- Errors: x_err = c_err while in BUSY_x, plus the d_rd & d_wr case for d_err. A c_err without c_done keeps the state; the cache sequence is never aborted.
- wait_cnt:
  - Increments, saturating at 2^WAIT_W-1, at each edge where ip=1 and fetch is not granted and not in BUSY_I.
  - Cleared on a fetch grant and whenever ip=0.
- Flush:
  - i_flush in IDLE: that fetch is ignored.
  - i_flush in BUSY_I: set flushed. The cache transaction runs to c_done, because a fill cannot be aborted. On that c_done, suppress i_done, i_hit and i_err, then clear flushed.
  - A new fetch can be granted only after that completion.
- Requester holding a request after its done: this is treated as a new request, granted no earlier than the next arbitration point.
- Simultaneous c_done and a new d request while in BUSY_D: the new request is not granted at this point.

Decomposition:
- Shared package: state encodings ARB_IDLE=2'b00, ARB_BUSY_I=2'b01, ARB_BUSY_D=2'b10, plus MAX_WAIT and WAIT_W defaults.
- One sub-module, arb_req_latch: 16b addr, 16b data, rd and wr registers with load enable and asynchronous active-low clear. Instantiated once.

Test Plan:
- Fetch hit: i_rd=1, i_addr=16'h0040, cache hit returns 16'hBEEF. Required: c_read=1 and c_addr=16'h0040 at N+1; i_done=1, i_data_out=16'hBEEF, i_hit=1 at N+1; i_stall=1 at N only.
- Contention: i_rd and d_wr (d_addr=16'h0100, d_data_in=16'h1234) asserted in the same cycle. Required: data granted first with c_write=1 and c_data_in=16'h1234. On d_done, fetch is granted at the same edge with no IDLE cycle.
- Starvation: d requests back-to-back continuously with i_rd held, MAX_WAIT=4. Required: fetch granted on the 5th arbitration point, wait_cnt cleared to 0.
- Flush mid-miss: fetch miss, i_flush pulsed 2 cycles after grant. Required: c_read held until c_done; i_done stays 0 throughout; the next fetch is granted after completion.
- Illegal op: d_rd=d_wr=1. Required: d_err=1 and c_read=c_write=0; state remains IDLE.
- Reset mid-miss: rst=0 while in BUSY_D. Required: immediate IDLE; all outputs 0; wait_cnt=0.
